fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch control for the pipelined MIPS core, sitting directly downstream of the program counter register. Each cycle it presents the current PC to the instruction memory/icache, waits for the hit, and computes the next PC (sequential or redirect) together with the PC write enable. It also owns the IF/ID pipeline latch, honouring hazard-unit stalls, branch/jump redirects and HALT.

## Interface
- RESET_INSTR, 32'h0000_0000, instruction word loaded into IF/ID on reset and on bubble/flush (nop)
- HALT_OP, 6'h3F, opcode (bits 31:26) that stops fetching
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- pco  in  32  current PC from the PC register
- pci  out  32  next PC to the PC register
- pc_wen  out  1  PC register write enable
- imemREN  out  1  instruction read request
- imemaddr  out  32  instruction address (= pco)
- ihit  in  1  instruction memory hit, imemload valid this cycle
- imemload  in  32  fetched instruction word
- stall  in  1  hazard unit: hold IF/ID and PC
- redirect  in  1  taken branch/jump from EX/MEM
- redirect_pc  in  32  redirect target, word-aligned
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_instr  out  32  IF/ID instruction
- ifid_npc  out  32  IF/ID PC+4 of that instruction
- fetch_halted  out  1  fetch stopped on HALT

## Operation
- States: FETCH, DRAIN, HALTED. Reset -> FETCH.
- Reset values: ifid_valid 0, ifid_instr RESET_INSTR, ifid_npc 0, pending target 0, fetch_halted 0.
- imemaddr = pco always; imemREN = 1 in FETCH and DRAIN, 0 in HALTED.
- FETCH, priority order:
  - redirect & ihit: pci = redirect_pc, pc_wen 1, IF/ID flushed (valid 0, instr RESET_INSTR); fetched word dropped.
  - redirect & !ihit: pending <= redirect_pc, pc_wen 0, IF/ID flushed, -> DRAIN (address held stable until the outstanding access completes).
  - stall: pc_wen 0, IF/ID held unchanged, regardless of ihit.
  - ihit: IF/ID <= {1, imemload, pco+4}; pci = pco+4, pc_wen 1; if imemload[31:26] == HALT_OP -> HALTED, pc_wen 0 (PC stays on HALT).
  - !ihit: pc_wen 0, IF/ID <= bubble.
- DRAIN: IF/ID bubble each cycle; redirect overwrites pending (latest wins); on ihit: word dropped, pci = pending (or redirect_pc if redirect same cycle), pc_wen 1, -> FETCH. stall ignored.
- HALTED: fetch_halted 1, pc_wen 0; IF/ID becomes bubble unless stall (then held). redirect -> pci = redirect_pc, pc_wen 1, IF/ID flushed, -> FETCH (squashed speculative HALT).
- Arithmetic: pco+4 modulo 2^32; wrap 32'hFFFF_FFFC -> 0 without error.
- Reset mid-access: all state cleared asynchronously; any outstanding memory access is abandoned.

## Timing
- pci, pc_wen, imemREN, imemaddr: combinational from state and inputs, same cycle.
- IF/ID, state, pending: update on CLK rising edge; fetched word visible on ifid_* one cycle after ihit.
- Back-to-back ihit with no stall: one instruction per cycle.
- Redirect to first fetch at target: 1 cycle when ihit coincides; otherwise ihit-of-outstanding + 1.

## Structure
- cpu_types_pkg: word_t, opcode_t with HALT, WBYTES (4); add fetch_state_t enum {FETCH, DRAIN, HALTED}.
- One sub-module: ifid_reg (IF/ID latch with load/hold/flush controls, async reset to the values above).
- Next-PC mux and FSM stay in fetch_stage.

## Test plan
- Reset, ihit tied 1, imemload = 32'h2001_0005 at every address: pci sequence 4, 8, 12; ifid_npc 4 one cycle after first hit.
- ihit low 3 cycles at pco 0x10: pc_wen 0, three bubbles (ifid_valid 0, instr RESET_INSTR); hit then ifid_npc 0x14.
- stall high 2 cycles with ihit 1: PC and IF/ID frozen; release -> pci = pco+4 next cycle.
- redirect to 0x100 while pco 0x20 waits (ihit 0): DRAIN, no PC write; ihit at cycle 3 -> pci 0x100, pc_wen 1; next fetch at 0x100, word at 0x20 never enters IF/ID.
- Fetch 32'hFC00_0000 at 0x40: IF/ID holds HALT, fetch_halted 1, imemREN 0, PC stays 0x40; redirect to 0x80 -> resume at 0x80.
- pco 32'hFFFF_FFFC with ihit -> pci 0; nRST low mid-DRAIN -> FETCH, ifid_valid 0 immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS core.
// Word, opcode, fetch FSM state and IF/ID bundle.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [5:0] {
      HALT = 6'h3F
   } opcode_t;

   localparam word_t WBYTES = 32'd4;
   localparam word_t RESET_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH,
      DRAIN,
      HALTED
   } fetch_state_t;

   typedef struct packed {
      logic  valid;
      word_t instr;
      word_t npc;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{
      valid: 1'b0,
      instr: RESET_INSTR,
      npc:   32'h0
   };

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline latch.
// Flush beats load; otherwise hold.
module ifid_reg
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  load,
   input  logic  flush,
   input  ifid_t d,
   output ifid_t q
);

   // latch update: bubble on reset/flush, new word on load
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         q <= IFID_BUBBLE;
      else if (flush)
         q <= IFID_BUBBLE;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch control and next-PC selection.
// Owns the IF/ID latch and the FETCH/DRAIN/HALTED FSM.
module fetch_stage
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] pco,
   output logic [31:0] pci,
   output logic        pc_wen,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_npc,
   output logic        fetch_halted
);

   fetch_state_t state, state_n;
   word_t        pending, pending_n;
   word_t        seq_pc;
   logic         is_halt;
   logic         ld, fl;
   ifid_t        ifid_d, ifid_q;

   assign seq_pc   = pco + WBYTES;
   assign is_halt  = (imemload[31:26] == HALT);
   assign imemaddr = pco;

   assign ifid_d = '{valid: 1'b1, instr: imemload, npc: seq_pc};

   // state and redirect target registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= FETCH;
         pending <= 32'h0;
      end else begin
         state   <= state_n;
         pending <= pending_n;
      end
   end

   // next-state, next-PC and IF/ID control
   always_comb begin
      state_n      = state;
      pending_n    = pending;
      pci          = seq_pc;
      pc_wen       = 1'b0;
      imemREN      = 1'b1;
      fetch_halted = 1'b0;
      ld           = 1'b0;
      fl           = 1'b0;
      unique case (state)
         FETCH: begin
            if (redirect && ihit) begin
               pci    = redirect_pc;
               pc_wen = 1'b1;
               fl     = 1'b1;
            end else if (redirect) begin
               pending_n = redirect_pc;
               fl        = 1'b1;
               state_n   = DRAIN;
            end else if (stall) begin
               pc_wen = 1'b0;
            end else if (ihit) begin
               ld = 1'b1;
               if (is_halt)
                  state_n = HALTED;
               else
                  pc_wen = 1'b1;
            end else begin
               fl = 1'b1;
            end
         end
         DRAIN: begin
            fl = 1'b1;
            if (redirect)
               pending_n = redirect_pc;
            if (ihit) begin
               pci     = redirect ? redirect_pc : pending;
               pc_wen  = 1'b1;
               state_n = FETCH;
            end
         end
         HALTED: begin
            imemREN      = 1'b0;
            fetch_halted = 1'b1;
            if (redirect) begin
               pci     = redirect_pc;
               pc_wen  = 1'b1;
               fl      = 1'b1;
               state_n = FETCH;
            end else if (!stall) begin
               fl = 1'b1;
            end
         end
         default: begin
            state_n = FETCH;
            fl      = 1'b1;
         end
      endcase
   end

   ifid_reg u_ifid (
      .CLK   (CLK),
      .nRST  (nRST),
      .load  (ld),
      .flush (fl),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign ifid_valid = ifid_q.valid;
   assign ifid_instr = ifid_q.instr;
   assign ifid_npc   = ifid_q.npc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// Directed table, reset corner, then random vs model.
module tb_fetch_stage;

   logic        CLK, nRST;
   logic [31:0] pco, pci, imemaddr, imemload, redirect_pc;
   logic [31:0] ifid_instr, ifid_npc;
   logic        pc_wen, imemREN, ihit, stall, redirect;
   logic        ifid_valid, fetch_halted;

   int checks = 0;
   int errors = 0;

   fetch_stage dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .pco          (pco),
      .pci          (pci),
      .pc_wen       (pc_wen),
      .imemREN      (imemREN),
      .imemaddr     (imemaddr),
      .ihit         (ihit),
      .imemload     (imemload),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .ifid_valid   (ifid_valid),
      .ifid_instr   (ifid_instr),
      .ifid_npc     (ifid_npc),
      .fetch_halted (fetch_halted)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ihit;
      logic [31:0] load;
      logic [31:0] pco;
      logic        e_wen;
      logic [31:0] e_pci;
      logic        e_ren;
      logic        e_hlt;
      logic        e_v;
      logic [31:0] e_instr;
      logic [31:0] e_npc;
   } vec_t;

   localparam logic [31:0] ADDI = 32'h2001_0005;
   localparam logic [31:0] HLT  = 32'hFC00_0000;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic s, input logic r, input logic [31:0] rp,
      input logic h, input logic [31:0] ld, input logic [31:0] pc,
      input logic w, input logic [31:0] np, input logic rn,
      input logic hl, input logic v, input logic [31:0] ins,
      input logic [31:0] nn);
      vec_t t;
      t.stall = s; t.redir = r; t.rpc = rp; t.ihit = h;
      t.load = ld; t.pco = pc; t.e_wen = w; t.e_pci = np;
      t.e_ren = rn; t.e_hlt = hl; t.e_v = v;
      t.e_instr = ins; t.e_npc = nn;
      return t;
   endfunction

   task automatic drive(input vec_t v);
      stall       = v.stall;
      redirect    = v.redir;
      redirect_pc = v.rpc;
      ihit        = v.ihit;
      imemload    = v.load;
      pco         = v.pco;
   endtask

   task automatic compare(input vec_t v);
      chk("pc_wen", {31'b0, pc_wen}, {31'b0, v.e_wen});
      if (v.e_wen)
         chk("pci", pci, v.e_pci);
      chk("imemREN", {31'b0, imemREN}, {31'b0, v.e_ren});
      chk("imemaddr", imemaddr, v.pco);
      chk("fetch_halted", {31'b0, fetch_halted}, {31'b0, v.e_hlt});
      chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, v.e_v});
      chk("ifid_instr", ifid_instr, v.e_instr);
      chk("ifid_npc", ifid_npc, v.e_npc);
   endtask

   task automatic apply(input vec_t v);
      drive(v);
      #2;
      compare(v);
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      stall = 0; redirect = 0; redirect_pc = 0;
      ihit = 0; imemload = 0; pco = 0;
      #3;
      chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
      chk("rst_instr", ifid_instr, 32'h0);
      chk("rst_npc", ifid_npc, 32'h0);
      chk("rst_halted", {31'b0, fetch_halted}, 32'h0);
      chk("rst_ren", {31'b0, imemREN}, 32'h1);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   vec_t tbl[$];

   // reference model state
   logic [31:0] m_pc, m_tgt, m_i, m_n;
   bit          m_halt, m_wait, m_v;

   initial begin
      vec_t r;
      int   act;
      nRST = 1'b0;
      #1;
      do_reset();

      //          s  r  rpc       h  load       pco           w  pci           rn hl v  instr npc
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'h0,        1,32'h4,        1,0,0,0,   0));
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'h4,        1,32'h8,        1,0,1,ADDI,32'h4));
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'h8,        1,32'hC,        1,0,1,ADDI,32'h8));
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'hC,        1,32'h10,       1,0,1,ADDI,32'hC));
      tbl.push_back(mk(0,0,0,        0,ADDI,       32'h10,       0,0,            1,0,1,ADDI,32'h10));
      tbl.push_back(mk(0,0,0,        0,ADDI,       32'h10,       0,0,            1,0,0,0,   0));
      tbl.push_back(mk(0,0,0,        0,ADDI,       32'h10,       0,0,            1,0,0,0,   0));
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'h10,       1,32'h14,       1,0,0,0,   0));
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'h14,       1,32'h18,       1,0,1,ADDI,32'h14));
      tbl.push_back(mk(1,0,0,        1,ADDI,       32'h18,       0,0,            1,0,1,ADDI,32'h18));
      tbl.push_back(mk(1,0,0,        1,ADDI,       32'h18,       0,0,            1,0,1,ADDI,32'h18));
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'h18,       1,32'h1C,       1,0,1,ADDI,32'h18));
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'h1C,       1,32'h20,       1,0,1,ADDI,32'h1C));
      tbl.push_back(mk(0,1,32'h100,  0,ADDI,       32'h20,       0,0,            1,0,1,ADDI,32'h20));
      tbl.push_back(mk(0,0,0,        0,ADDI,       32'h20,       0,0,            1,0,0,0,   0));
      tbl.push_back(mk(0,0,0,        1,32'hDEADBEEF,32'h20,      1,32'h100,      1,0,0,0,   0));
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'h100,      1,32'h104,      1,0,0,0,   0));
      tbl.push_back(mk(0,0,0,        0,ADDI,       32'h104,      0,0,            1,0,1,ADDI,32'h104));
      tbl.push_back(mk(0,0,0,        1,HLT,        32'h40,       0,0,            1,0,0,0,   0));
      tbl.push_back(mk(0,0,0,        1,HLT,        32'h40,       0,0,            0,1,1,HLT, 32'h44));
      tbl.push_back(mk(0,0,0,        1,HLT,        32'h40,       0,0,            0,1,0,0,   0));
      tbl.push_back(mk(0,1,32'h80,   1,HLT,        32'h40,       1,32'h80,       0,1,0,0,   0));
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'h80,       1,32'h84,       1,0,0,0,   0));
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'hFFFFFFFC, 1,32'h0,        1,0,1,ADDI,32'h84));
      tbl.push_back(mk(0,0,0,        1,ADDI,       32'h0,        1,32'h4,        1,0,1,ADDI,32'h0));

      foreach (tbl[i])
         apply(tbl[i]);

      // reset in the middle of a drain abandons the pending redirect
      apply(mk(0,1,32'h500, 0,ADDI, 32'h300, 0,0, 1,0,1,ADDI,32'h4));
      drive(mk(0,0,0, 0,ADDI, 32'h300, 0,0, 1,0,0,0,0));
      #2;
      nRST = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, ifid_valid}, 32'h0);
      chk("mid_rst_wen", {31'b0, pc_wen}, 32'h0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      apply(mk(0,0,0, 1,ADDI, 32'h200, 1,32'h204, 1,0,0,0,0));

      // randomized run against the behavioural model
      do_reset();
      m_pc = {$urandom_range(0, 32'h3FFF), 2'b00};
      m_halt = 0; m_wait = 0; m_tgt = 0;
      m_v = 0; m_i = 0; m_n = 0;
      for (int c = 0; c < 500; c++) begin
         r.stall = ($urandom_range(0, 3) == 0);
         r.redir = ($urandom_range(0, 6) == 0);
         r.rpc   = {$urandom_range(0, 32'h3FFF), 2'b00};
         r.ihit  = ($urandom_range(0, 9) < 6);
         r.load  = ($urandom_range(0, 9) == 0) ?
                   {6'h3F, 26'($urandom)} : $urandom;
         if (r.load[31:26] == 6'h3F && $urandom_range(0, 1) == 0)
            r.load[31:26] = 6'h08;
         r.pco     = m_pc;
         r.e_ren   = !m_halt;
         r.e_hlt   = m_halt;
         r.e_v     = m_v;
         r.e_instr = m_i;
         r.e_npc   = m_n;
         r.e_wen   = 0;
         r.e_pci   = 0;
         // act: 0 hold, 1 bubble, 2 capture fetched word
         act = 0;
         if (m_halt) begin
            if (r.redir) begin
               r.e_wen = 1; r.e_pci = r.rpc;
               act = 1; m_halt = 0;
            end else if (!r.stall) begin
               act = 1;
            end
         end else if (m_wait) begin
            act = 1;
            if (r.redir) m_tgt = r.rpc;
            if (r.ihit) begin
               r.e_wen = 1; r.e_pci = m_tgt;
               m_wait = 0;
            end
         end else if (r.redir) begin
            act = 1;
            if (r.ihit) begin
               r.e_wen = 1; r.e_pci = r.rpc;
            end else begin
               m_wait = 1; m_tgt = r.rpc;
            end
         end else if (r.stall) begin
            act = 0;
         end else if (r.ihit) begin
            act = 2;
            if (r.load[31:26] == 6'h3F) begin
               m_halt = 1;
            end else begin
               r.e_wen = 1; r.e_pci = m_pc + 32'd4;
            end
         end else begin
            act = 1;
         end
         apply(r);
         if (act == 1) begin
            m_v = 0; m_i = 0; m_n = 0;
         end else if (act == 2) begin
            m_v = 1; m_i = r.load; m_n = m_pc + 32'd4;
         end
         if (r.e_wen) m_pc = r.e_pci;
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
